// File: rtl/floo_link_isolate_buffer.sv
// floo_link_isolate_buffer
// Registered, packet-aware link buffer for one NoC channel. On an isolation
// request it closes the input only at a packet boundary, drains what it
// holds, then reports itself isolated.
module floo_link_isolate_buffer #(
    parameter type         flit_t   = logic [63:0],
    parameter int unsigned Depth    = 2,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                isolate_i,
    output logic                isolated_o,
    input  logic                valid_i,
    output logic                ready_o,
    input  flit_t               data_i,
    input  logic                last_i,
    output logic                valid_o,
    input  logic                ready_i,
    output flit_t               data_o,
    output logic                last_o,
    output logic [CntWidth-1:0] occupancy_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        ISOLATED
    } state_e;

    state_e state_q;
    ptr_t   wr_ptr_q;
    ptr_t   rd_ptr_q;
    cnt_t   count_q;
    cnt_t   count_next;
    logic   pkt_open_q;
    logic   isolated_q;
    logic   push;
    logic   pop;

    flit_t  data_mem_q [Depth];
    logic   last_mem_q [Depth];

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Handshakes and next occupancy; ready_o never depends on ready_i or valid_i.
    always_comb begin
        ready_o = rst_ni && (state_q == RUN) && (count_q < cnt_t'(Depth))
                  && !(isolate_i && !pkt_open_q);
        valid_o    = (count_q != '0);
        push       = valid_i && ready_o;
        pop        = valid_o && ready_i;
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + cnt_t'(1);
        end else if (pop && !push) begin
            count_next = count_q - cnt_t'(1);
        end
    end

    assign data_o      = data_mem_q[rd_ptr_q];
    assign last_o      = last_mem_q[rd_ptr_q];
    assign occupancy_o = count_q;
    assign isolated_o  = isolated_q;

    // Payload storage; unreset, since count_q alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= data_i;
            last_mem_q[wr_ptr_q] <= last_i;
        end
    end

    // Pointers, occupancy, packet tracking and isolation FSM with registered isolated flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_open_q <= 1'b0;
            isolated_q <= 1'b0;
        end else begin
            count_q <= count_next;
            if (push) begin
                wr_ptr_q   <= ptr_inc(wr_ptr_q);
                pkt_open_q <= !last_i;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case (state_q)
                RUN: begin
                    if (isolate_i && !pkt_open_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!isolate_i) begin
                        state_q <= RUN;
                    end else if (count_next == '0) begin
                        state_q    <= ISOLATED;
                        isolated_q <= 1'b1;
                    end
                end
                ISOLATED: begin
                    if (!isolate_i) begin
                        state_q    <= RUN;
                        isolated_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    isolated_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floo_link_isolate_buffer.sv
// tb_floo_link_isolate_buffer
// Directed scenarios for the isolating link buffer with Depth=2.
module tb_floo_link_isolate_buffer;

    logic        clk;
    logic        rst_ni;
    logic        isolate_i;
    logic        isolated_o;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic        last_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] data_o;
    logic        last_o;
    logic [1:0]  occupancy_o;

    int n_cmp = 0;
    int n_err = 0;

    floo_link_isolate_buffer #(
        .flit_t (logic [63:0]),
        .Depth  (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .isolate_i   (isolate_i),
        .isolated_o  (isolated_o),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .last_i      (last_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .last_o      (last_o),
        .occupancy_o (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive upstream inputs, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [63:0] d, input logic l);
        valid_i = v;
        data_i  = d;
        last_i  = l;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; isolate_i = 1'b0; ready_i = 1'b0;
        drive(1'b1, 64'hDEAD, 1'b1);
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        cycle();
        cycle();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (occupancy_o !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
        n_cmp++; if (isolated_o !== 1'b0) begin n_err++; $display("FAIL reset_isolated: got %b want 0", isolated_o); end
        rst_ni = 1'b1;
        drive(1'b0, 64'h0, 1'b0);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(i + 1), 1'b1);
            n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", i, ready_o); end
            if (i == 0) begin
                n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL stream_first_valid: got %b want 0", valid_o); end
            end else begin
                n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'(i)) begin n_err++; $display("FAIL stream_data[%0d]: got v=%b d=%0h want v=1 d=%0h", i, valid_o, data_o, i); end
                n_cmp++; if (occupancy_o !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy_o); end
            end
            cycle();
        end
        drive(1'b0, 64'h0, 1'b0);
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'h8 || last_o !== 1'b1) begin n_err++; $display("FAIL stream_last: got v=%b d=%0h l=%b want v=1 d=8 l=1", valid_o, data_o, last_o); end
        cycle();
        n_cmp++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin n_err++; $display("FAIL stream_empty: got v=%b occ=%0d want v=0 occ=0", valid_o, occupancy_o); end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        drive(1'b1, 64'hA0, 1'b1);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready0: got %b want 1", ready_o); end
        cycle();
        drive(1'b1, 64'hA1, 1'b1);
        n_cmp++; if (ready_o !== 1'b1 || occupancy_o !== 2'd1) begin n_err++; $display("FAIL bp_ready1: got r=%b occ=%0d want r=1 occ=1", ready_o, occupancy_o); end
        cycle();
        drive(1'b1, 64'hA2, 1'b1);
        n_cmp++; if (occupancy_o !== 2'd2) begin n_err++; $display("FAIL bp_full_occ: got %0d want 2", occupancy_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", ready_o); end
        cycle();
        ready_i = 1'b1;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full_ready_with_ready_i: got %b want 0", ready_o); end
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'hA0) begin n_err++; $display("FAIL bp_out0: got v=%b d=%0h want v=1 d=a0", valid_o, data_o); end
        cycle();
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop: got %b want 1", ready_o); end
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'hA1) begin n_err++; $display("FAIL bp_out1: got v=%b d=%0h want v=1 d=a1", valid_o, data_o); end
        cycle();
        drive(1'b0, 64'h0, 1'b0);
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'hA2) begin n_err++; $display("FAIL bp_out2: got v=%b d=%0h want v=1 d=a2", valid_o, data_o); end
        cycle();
        n_cmp++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin n_err++; $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", valid_o, occupancy_o); end
    endtask

    task automatic test_isolate_idle();
        ready_i = 1'b1;
        isolate_i = 1'b1;
        drive(1'b1, 64'h99, 1'b1);
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL idle_ready_same_cycle: got %b want 0", ready_o); end
        cycle();
        n_cmp++; if (ready_o !== 1'b0 || isolated_o !== 1'b0) begin n_err++; $display("FAIL idle_drain: got r=%b iso=%b want r=0 iso=0", ready_o, isolated_o); end
        cycle();
        n_cmp++; if (isolated_o !== 1'b1) begin n_err++; $display("FAIL idle_isolated: got %b want 1", isolated_o); end
        n_cmp++; if (ready_o !== 1'b0 || valid_o !== 1'b0 || occupancy_o !== 2'd0) begin n_err++; $display("FAIL idle_closed: got r=%b v=%b occ=%0d want 0 0 0", ready_o, valid_o, occupancy_o); end
        isolate_i = 1'b0;
        drive(1'b0, 64'h0, 1'b0);
        n_cmp++; if (isolated_o !== 1'b1 || ready_o !== 1'b0) begin n_err++; $display("FAIL idle_release_same_cycle: got iso=%b r=%b want iso=1 r=0", isolated_o, ready_o); end
        cycle();
        n_cmp++; if (isolated_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL idle_rerun: got iso=%b r=%b want iso=0 r=1", isolated_o, ready_o); end
    endtask

    task automatic test_isolate_mid_packet();
        ready_i = 1'b1;
        isolate_i = 1'b0;
        drive(1'b1, 64'h10, 1'b0);
        cycle();
        drive(1'b1, 64'h11, 1'b0);
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'h10) begin n_err++; $display("FAIL mid_out10: got v=%b d=%0h want v=1 d=10", valid_o, data_o); end
        cycle();
        isolate_i = 1'b1;
        drive(1'b1, 64'h12, 1'b0);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL mid_accept12: got %b want 1", ready_o); end
        n_cmp++; if (data_o !== 64'h11) begin n_err++; $display("FAIL mid_out11: got %0h want 11", data_o); end
        cycle();
        drive(1'b1, 64'h13, 1'b1);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL mid_accept13: got %b want 1", ready_o); end
        n_cmp++; if (data_o !== 64'h12 || last_o !== 1'b0) begin n_err++; $display("FAIL mid_out12: got d=%0h l=%b want d=12 l=0", data_o, last_o); end
        cycle();
        drive(1'b1, 64'h20, 1'b1);
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL mid_closed_after13: got %b want 0", ready_o); end
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'h13 || last_o !== 1'b1) begin n_err++; $display("FAIL mid_out13: got v=%b d=%0h l=%b want v=1 d=13 l=1", valid_o, data_o, last_o); end
        cycle();
        n_cmp++; if (ready_o !== 1'b0 || valid_o !== 1'b0 || isolated_o !== 1'b0) begin n_err++; $display("FAIL mid_drain: got r=%b v=%b iso=%b want 0 0 0", ready_o, valid_o, isolated_o); end
        cycle();
        n_cmp++; if (isolated_o !== 1'b1) begin n_err++; $display("FAIL mid_isolated: got %b want 1", isolated_o); end
        cycle();
        n_cmp++; if (isolated_o !== 1'b1 || occupancy_o !== 2'd0 || ready_o !== 1'b0) begin n_err++; $display("FAIL mid_hold: got iso=%b occ=%0d r=%b want iso=1 occ=0 r=0", isolated_o, occupancy_o, ready_o); end
        isolate_i = 1'b0;
        drive(1'b0, 64'h0, 1'b0);
        cycle();
        n_cmp++; if (isolated_o !== 1'b0 || valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rerun: got iso=%b v=%b want iso=0 v=0", isolated_o, valid_o); end
    endtask

    task automatic test_abort_drain();
        ready_i = 1'b0;
        isolate_i = 1'b0;
        drive(1'b1, 64'hB0, 1'b1);
        cycle();
        drive(1'b1, 64'hB1, 1'b1);
        cycle();
        isolate_i = 1'b1;
        drive(1'b0, 64'h0, 1'b0);
        n_cmp++; if (occupancy_o !== 2'd2 || ready_o !== 1'b0) begin n_err++; $display("FAIL abort_full: got occ=%0d r=%b want occ=2 r=0", occupancy_o, ready_o); end
        cycle();
        n_cmp++; if (isolated_o !== 1'b0 || occupancy_o !== 2'd2) begin n_err++; $display("FAIL abort_in_drain: got iso=%b occ=%0d want iso=0 occ=2", isolated_o, occupancy_o); end
        isolate_i = 1'b0;
        cycle();
        #1;
        n_cmp++; if (ready_o !== 1'b0 || isolated_o !== 1'b0) begin n_err++; $display("FAIL abort_run_full: got r=%b iso=%b want r=0 iso=0", ready_o, isolated_o); end
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'hB0) begin n_err++; $display("FAIL abort_outB0: got v=%b d=%0h want v=1 d=b0", valid_o, data_o); end
        ready_i = 1'b1;
        cycle();
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL abort_run_ready: got %b want 1", ready_o); end
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'hB1) begin n_err++; $display("FAIL abort_outB1: got v=%b d=%0h want v=1 d=b1", valid_o, data_o); end
        cycle();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL abort_empty: got %b want 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        isolate_i = 1'b0;
        drive(1'b1, 64'hC0, 1'b0);
        cycle();
        drive(1'b1, 64'hC1, 1'b0);
        cycle();
        drive(1'b0, 64'h0, 1'b0);
        n_cmp++; if (occupancy_o !== 2'd2) begin n_err++; $display("FAIL rstmid_occ_before: got %0d want 2", occupancy_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ready_in_reset: got %b want 0", ready_o); end
        cycle();
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0 || isolated_o !== 1'b0) begin n_err++; $display("FAIL rstmid_cleared: got v=%b occ=%0d iso=%b want 0 0 0", valid_o, occupancy_o, isolated_o); end
        // pkt_open was cleared, so an isolation request closes the input at once
        isolate_i = 1'b1;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_pkt_closed: got %b want 0", ready_o); end
        isolate_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b1, 64'h55, 1'b1);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_accept55: got %b want 1", ready_o); end
        cycle();
        drive(1'b0, 64'h0, 1'b0);
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'h55 || occupancy_o !== 2'd1) begin n_err++; $display("FAIL rstmid_out55: got v=%b d=%0h occ=%0d want v=1 d=55 occ=1", valid_o, data_o, occupancy_o); end
        cycle();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_empty: got %b want 0", valid_o); end
    endtask

    initial begin
        rst_ni = 1'b0; isolate_i = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b0;
        cycle();
        test_reset();
        test_streaming();
        test_backpressure();
        test_isolate_idle();
        test_isolate_mid_packet();
        test_abort_drain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
